// File: rtl/control_sequencer_pkg.sv
// Shared opcode, ALU-code and state definitions for the hardwired control sequencer.
// Also holds the opcode-class and ALU-code decode helpers.
package control_defs;

    typedef enum logic [4:0] {
        OPC_ADD  = 5'b00011, OPC_SUB  = 5'b00100, OPC_AND  = 5'b00101,
        OPC_OR   = 5'b00110, OPC_SHR  = 5'b00111, OPC_SHRA = 5'b01000,
        OPC_SHL  = 5'b01001, OPC_ROR  = 5'b01010, OPC_ROL  = 5'b01011,
        OPC_ADDI = 5'b01100, OPC_ANDI = 5'b01101, OPC_ORI  = 5'b01110,
        OPC_MUL  = 5'b01111, OPC_DIV  = 5'b10000, OPC_NEG  = 5'b10001,
        OPC_NOT  = 5'b10010, OPC_NOP  = 5'b11010, OPC_HALT = 5'b11011
    } opcode_t;

    typedef enum logic [4:0] {
        ALU_NONE = 5'b00000,
        ALU_ADD  = 5'b00100, ALU_SUB  = 5'b00101, ALU_AND  = 5'b00110,
        ALU_OR   = 5'b00111, ALU_SHR  = 5'b01000, ALU_SHRA = 5'b01001,
        ALU_SHL  = 5'b01010, ALU_ROR  = 5'b01011, ALU_ROL  = 5'b01100,
        ALU_MUL  = 5'b10000, ALU_DIV  = 5'b10001, ALU_NEG  = 5'b10010,
        ALU_NOT  = 5'b10011
    } alu_op_t;

    typedef enum logic [3:0] {
        S_RST  = 4'd0,
        T0     = 4'd1,
        T1     = 4'd2,
        T2     = 4'd3,
        T3     = 4'd4,
        T4     = 4'd5,
        T5     = 4'd6,
        T6     = 4'd7,
        S_HALT = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        CL_ALU3,
        CL_IMM,
        CL_MULDIV,
        CL_UNARY,
        CL_NOP,
        CL_STOP
    } iclass_t;

    function automatic iclass_t classify(input logic [4:0] opc);
        if (opc inside {[OPC_ADD:OPC_ROL]})        return CL_ALU3;
        else if (opc inside {[OPC_ADDI:OPC_ORI]})  return CL_IMM;
        else if (opc inside {OPC_MUL, OPC_DIV})    return CL_MULDIV;
        else if (opc inside {OPC_NEG, OPC_NOT})    return CL_UNARY;
        else if (opc == OPC_NOP)                   return CL_NOP;
        else                                       return CL_STOP;
    endfunction

    // Register and unary ALU codes sit one above their opcodes; immediates reuse the base op.
    function automatic logic [4:0] alu_map(input logic [4:0] opc);
        case (opc)
            OPC_ADDI: return ALU_ADD;
            OPC_ANDI: return ALU_AND;
            OPC_ORI:  return ALU_OR;
            default:  return (classify(opc) inside {CL_ALU3, CL_MULDIV, CL_UNARY})
                             ? opc + 5'd1 : ALU_NONE;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_reg_select.sv
// Register-field decoder: turns a register number into a one-hot select,
// all zeros when disabled.
module reg_select_decoder #(
    parameter  int NREG = 16,
    localparam int SELW = $clog2(NREG)
) (
    input  logic [SELW-1:0] sel,
    input  logic            en,
    output logic [NREG-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en)
            onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetches, decodes IR and issues one step of datapath
// strobes per clock. Moore outputs come from the state plus the fed-back IR.
module control_sequencer
    import control_defs::*;
#(
    parameter int OPW  = 5,
    parameter int NREG = 16
) (
    input  logic            Clock,
    input  logic            Clear,
    input  logic [31:0]     IR,
    input  logic            Stop,
    output logic            Run,
    output logic [NREG-1:0] reg_in,
    output logic [NREG-1:0] reg_out,
    output logic            PCin,
    output logic            PCout,
    output logic            IncPC,
    output logic            MARin,
    output logic            MDRin,
    output logic            MDRout,
    output logic            Read,
    output logic            IRin,
    output logic            Yin,
    output logic            ZHighin,
    output logic            ZLowin,
    output logic            ZHighout,
    output logic            ZLowout,
    output logic            HIin,
    output logic            LOin,
    output logic            Cout,
    output logic [OPW-1:0]  OP,
    output logic [3:0]      state_dbg
);

    localparam int SELW = $clog2(NREG);

    state_t          state, next_state;
    iclass_t         cls;
    logic [4:0]      alu_code;
    logic [SELW-1:0] ra, rb, rc;
    logic [SELW-1:0] in_sel, out_sel;
    logic            in_en, out_en;
    logic [4:0]      op_val;
    logic            unused_c;

    assign cls      = classify(IR[31:27]);
    assign alu_code = alu_map(IR[31:27]);
    assign ra       = SELW'(IR[26:23]);
    assign rb       = SELW'(IR[22:19]);
    assign rc       = SELW'(IR[18:15]);
    assign unused_c = ^IR[14:0];

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear)
            state <= S_RST;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        Run      = 1'b0;
        PCin     = 1'b0;  PCout   = 1'b0;  IncPC    = 1'b0;  MARin   = 1'b0;
        MDRin    = 1'b0;  MDRout  = 1'b0;  Read     = 1'b0;  IRin    = 1'b0;
        Yin      = 1'b0;  ZHighin = 1'b0;  ZLowin   = 1'b0;  ZHighout = 1'b0;
        ZLowout  = 1'b0;  HIin    = 1'b0;  LOin     = 1'b0;  Cout    = 1'b0;
        in_en    = 1'b0;  in_sel  = '0;
        out_en   = 1'b0;  out_sel = '0;
        op_val   = '0;

        case (state)
            S_RST: next_state = T0;
            T0: begin
                Run = 1'b1;
                PCout = 1'b1;  MARin = 1'b1;  IncPC = 1'b1;
                next_state = T1;
            end
            T1: begin
                Run = 1'b1;
                PCin = 1'b1;  Read = 1'b1;  MDRin = 1'b1;
                next_state = T2;
            end
            T2: begin
                Run = 1'b1;
                MDRout = 1'b1;  IRin = 1'b1;
                next_state = T3;
            end
            T3: begin
                Run = 1'b1;
                case (cls)
                    CL_ALU3, CL_IMM, CL_MULDIV: begin
                        out_en = 1'b1;  out_sel = rb;  Yin = 1'b1;
                        next_state = T4;
                    end
                    CL_UNARY: next_state = T4;
                    CL_NOP:   next_state = Stop ? S_HALT : T0;
                    default:  next_state = S_HALT;
                endcase
            end
            T4: begin
                Run = 1'b1;
                op_val = alu_code;
                ZLowin = 1'b1;
                case (cls)
                    CL_ALU3:   begin out_en = 1'b1; out_sel = rc; end
                    CL_MULDIV: begin out_en = 1'b1; out_sel = rc; ZHighin = 1'b1; end
                    CL_IMM:    Cout = 1'b1;
                    CL_UNARY:  begin out_en = 1'b1; out_sel = rb; end
                    default:   ;
                endcase
                next_state = T5;
            end
            T5: begin
                Run = 1'b1;
                op_val = alu_code;
                ZLowout = 1'b1;
                if (cls == CL_MULDIV) begin
                    LOin = 1'b1;
                    next_state = T6;
                end else begin
                    in_en = 1'b1;  in_sel = ra;
                    next_state = Stop ? S_HALT : T0;
                end
            end
            T6: begin
                Run = 1'b1;
                op_val = alu_code;
                ZHighout = 1'b1;  HIin = 1'b1;
                next_state = Stop ? S_HALT : T0;
            end
            S_HALT: next_state = S_HALT;
            default: next_state = S_RST;
        endcase
    end

    reg_select_decoder #(.NREG(NREG)) u_reg_in_dec (
        .sel    (in_sel),
        .en     (in_en),
        .onehot (reg_in)
    );

    reg_select_decoder #(.NREG(NREG)) u_reg_out_dec (
        .sel    (out_sel),
        .en     (out_en),
        .onehot (reg_out)
    );

    assign OP        = OPW'(op_val);
    assign state_dbg = state;

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit directly upstream of `datapath`; replaces the hand-driven T0..T5 control sequences used in the per-instruction benches.
- Fetches an instruction, decodes IR, and drives every datapath load/drive strobe for one clock per step.
- Covers three-register ALU/shift ops, immediate ALU ops, two-register ops, mul/div (HI/LO writeback), nop and halt.
- Moore outputs are decoded from the state register and the IR value fed back from the datapath.

Parameters:
- `OPW`, 5, opcode/ALU-op width.
- `NREG`, 16, general registers; sets the width of the one-hot register-select outputs.

Ports:
- `Clock` in 1: system clock, rising edge.
- `Clear` in 1: asynchronous, active-high reset.
- `IR` in 32: instruction register contents from datapath.
- `Stop` in 1: request halt at the next instruction boundary.
- `Run` out 1: high while sequencing; low in reset/halt.
- `reg_in` out 16: one-hot R0in..R15in.
- `reg_out` out 16: one-hot R0out..R15out.
- `PCin` `PCout` `IncPC` `MARin` `MDRin` `MDRout` `Read` `IRin` `Yin` out 1 each: datapath strobes.
- `ZHighin` `ZLowin` `ZHighout` `ZLowout` `HIin` `LOin` `Cout` out 1 each: datapath strobes.
- `OP` out 5: ALU operation code.
- `state_dbg` out 4: current state encoding, for benches.

Behaviour:
- IR fields: opcode=IR[31:27], Ra=IR[26:23] (dest), Rb=IR[22:19], Rc=IR[18:15], C=IR[18:0] (consumed by the datapath's Cout path).
- States: S_RST, T0, T1, T2, T3, T4, T5, T6, S_HALT.
- Every output not listed for a state is 0.
- `Clear` high (async) → state S_RST immediately, all outputs 0, `Run`=0; this applies mid-instruction too, and no partial writeback occurs afterwards.
- S_RST → T0 on the first edge after `Clear` deasserts; `Run`=1 from T0 on.
- T0: `PCout`, `MARin`, `IncPC` high.
- T1: `PCin`, `Read`, `MDRin` high.
- T2: `MDRout`, `IRin` high. IR is valid from T3 onwards.
- T3:
  - three-reg, immediate, mul/div: `reg_out`[Rb], `Yin`.
  - neg/not: no strobes (dummy step; keeps a uniform length).
  - nop: go to T0 without strobes.
  - halt: go to S_HALT.
  - undefined opcode: go to S_HALT.
- T4:
  - three-reg and mul/div: `reg_out`[Rc], `OP`, `ZLowin`. mul/div additionally assert `ZHighin`.
  - immediate: `Cout`, `OP`, `ZLowin`.
  - neg/not: `reg_out`[Rb], `OP`, `ZLowin`.
- T5:
  - all ALU classes except mul/div: `ZLowout`, `reg_in`[Ra].
  - mul/div: `ZLowout`, `LOin`.
- T6 (mul/div only): `ZHighout`, `HIin`.
- Instruction end (last execute state) → T0, or S_HALT if `Stop`=1 sampled on that edge.
- S_HALT: all strobes 0, `Run`=0; exits only via `Clear`.
- Latency:
  - 6 cycles for ALU, shift, immediate, neg and not.
  - 7 cycles for mul/div.
  - 4 cycles for nop.
- OP mapping:
  - add..rol, mul, div, neg, not: OP = opcode+1.
  - immediates: addi→ADD, andi→AND, ori→OR.
  - `OP` holds the value of the current instruction from T4 through instruction end; it is 0 elsewhere.
- R0 is selectable like any other register; no write suppression.
- `reg_in` and `reg_out` are never multi-hot.
- `Stop` asserted during fetch does not abort that instruction.

Decomposition:
- Package `control_defs`:
  - opcodes: ADD 00011, SUB 00100, AND 00101, OR 00110, SHR 00111, SHRA 01000, SHL 01001, ROR 01010, ROL 01011, ADDI 01100, ANDI 01101, ORI 01110, MUL 01111, DIV 10000, NEG 10001, NOT 10010, NOP 11010, HALT 11011.
  - ALU codes: ADD 00100, SUB 00101, AND 00110, OR 00111, SHR 01000, SHRA 01001, SHL 01010, ROR 01011, ROL 01100, MUL 10000, DIV 10001, NEG 10010, NOT 10011.
  - state encodings.
- Sub-module `reg_select_decoder`: 4-bit field → 16-bit one-hot, with an enable input; instantiated twice (`reg_in`, `reg_out`).

Test Plan:
- Reset, then IR=389A8000 (shr R1,R3,R5) → T3 `reg_out`=0x0008 with `Yin`; T4 `reg_out`=0x0020, `OP`=01000, `ZLowin`; T5 `reg_in`=0x0002 with `ZLowout`; back to T0 at cycle 7.
- IR=7A1C8000 (mul, Rb=R3, Rc=R9) → T4 `ZHighin`=`ZLowin`=1, `OP`=10000; T5 `LOin`; T6 `HIin`; no `reg_in` bit set in the whole instruction.
- IR=6100000F (addi R2,R0,15) → T4 `Cout`=1, `OP`=00100, `reg_out`=0; T5 `reg_in`=0x0004.
- IR=D8000000 (halt) → S_HALT after T3, `Run`=0 held for 20 cycles; `Clear` pulse → T0 next cycle after release.
- `Clear` asserted asynchronously mid-T4 → all outputs 0 immediately (before next edge), `state_dbg`=S_RST, no T5 strobes.
- `Stop`=1 during T1 of an add → instruction completes its T5 writeback, then S_HALT; IR=F8000000 (undefined opcode) → S_HALT after T3.
